// File: rtl/ysyx_24100006_gpr_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100006_gpr_scoreboard
// Brief    : Read-after-write hazard controller for the GPR file. Keeps a
//            pending-write counter per architectural register; issue in ID
//            increments it, retire in WB decrements it. ID is stalled while
//            a source it reads, or a saturated destination, is outstanding.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_24100006_gpr_scoreboard #(
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         id_valid,
    input  logic [ADDR_WIDTH-1:0]        id_rs1,
    input  logic [ADDR_WIDTH-1:0]        id_rs2,
    input  logic                         id_use_rs1,
    input  logic                         id_use_rs2,
    input  logic [ADDR_WIDTH-1:0]        id_rd,
    input  logic                         id_rd_wen,
    output logic                         id_stall,
    input  logic                         wb_valid,
    input  logic [ADDR_WIDTH-1:0]        wb_rd,
    input  logic                         wb_wen,
    input  logic                         flush,
    output logic [(2**ADDR_WIDTH)-1:0]   busy_mask,
    output logic                         sb_err
);

    localparam int              c_nreg    = 2 ** ADDR_WIDTH;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0]  r_cnt [c_nreg];
    logic [c_nreg-1:0] r_busy;
    logic              r_err;

    logic [CNT_W-1:0]  w_cnt_nxt [c_nreg];
    logic [c_nreg-1:0] w_busy_nxt;
    logic [c_nreg-1:0] w_inc_oh;
    logic [c_nreg-1:0] w_dec_oh;
    logic              w_h1;
    logic              w_h2;
    logic              w_hs;
    logic              w_issue;
    logic              w_retire;
    logic              w_err;

    // Hazard detection looks only at registered counts: a write retiring this
    // cycle lands in the GPR at the edge, so its data is usable next cycle.
    assign w_h1     = id_use_rs1 & (id_rs1 != '0) & (r_cnt[id_rs1] != '0);
    assign w_h2     = id_use_rs2 & (id_rs2 != '0) & (r_cnt[id_rs2] != '0);
    assign w_hs     = id_rd_wen  & (id_rd  != '0) & (r_cnt[id_rd] == c_cnt_max);
    assign id_stall = id_valid & (w_h1 | w_h2 | w_hs) & ~flush;

    assign w_issue  = id_valid & ~id_stall & ~flush & id_rd_wen & (id_rd != '0);
    assign w_retire = wb_valid & wb_wen & (wb_rd != '0) & ~flush;

    // Retiring a register with nothing outstanding is a pipeline protocol bug.
    assign w_err    = w_retire & (r_cnt[wb_rd] == '0);

    // One-hot increment/decrement selects per register.
    assign w_inc_oh = {{(c_nreg-1){1'b0}}, w_issue}  << id_rd;
    assign w_dec_oh = {{(c_nreg-1){1'b0}}, w_retire} << wb_rd;

    // Next counter values; same-index issue+retire cancel, flush wins over all.
    always_comb begin
        w_busy_nxt = '0;
        for (int i = 0; i < c_nreg; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (flush) begin
                w_cnt_nxt[i] = '0;
            end else if (w_inc_oh[i] && !w_dec_oh[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end else if (w_dec_oh[i] && !w_inc_oh[i] && (r_cnt[i] != '0)) begin
                w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
            end
        end
        // x0 is hardwired to zero and never tracked.
        w_cnt_nxt[0] = '0;
        for (int i = 0; i < c_nreg; i++) begin
            w_busy_nxt[i] = (w_cnt_nxt[i] != '0);
        end
    end

    // Counter, busy mask and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_nreg; i++) begin
                r_cnt[i] <= '0;
            end
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            for (int i = 0; i < c_nreg; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_busy <= w_busy_nxt;
            if (w_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy_mask = r_busy;
    assign sb_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100006_gpr_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24100006_gpr_scoreboard
// Brief    : Self-checking bench for the GPR scoreboard. A behavioural model
//            predicts stall, busy mask and error; registered expectations are
//            queued at drive time and popped after the clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_24100006_gpr_scoreboard;

    localparam int ADDR_WIDTH = 4;
    localparam int CNT_W      = 2;
    localparam int NREG       = 2 ** ADDR_WIDTH;
    localparam int CMAX       = 2 ** CNT_W - 1;

    logic                  clk;
    logic                  rst_n;
    logic                  id_valid;
    logic [ADDR_WIDTH-1:0] id_rs1;
    logic [ADDR_WIDTH-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [ADDR_WIDTH-1:0] id_rd;
    logic                  id_rd_wen;
    logic                  id_stall;
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic                  wb_wen;
    logic                  flush;
    logic [NREG-1:0]       busy_mask;
    logic                  sb_err;

    typedef struct {
        logic [NREG-1:0] busy;
        logic            err;
    } exp_t;

    exp_t sb_q[$];
    int   m_cnt [NREG];
    logic m_err;
    logic last_stall;
    int   n_chk;
    int   n_err;

    ysyx_24100006_gpr_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_rd_wen  (id_rd_wen),
        .id_stall   (id_stall),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_wen     (wb_wen),
        .flush      (flush),
        .busy_mask  (busy_mask),
        .sb_err     (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] b;
        b = '0;
        for (int i = 1; i < NREG; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    // One clock of stimulus. Called just after a posedge; returns just after the next.
    task automatic cyc(input logic v, input int rs1, input logic u1, input int rs2, input logic u2,
                       input int rd, input logic wen, input logic wbv, input int wbrd,
                       input logic wbwen, input logic fl, input string tag);
        logic exp_stall, iss, ret;
        exp_t e, o;
        id_valid = v;   id_rs1 = rs1[ADDR_WIDTH-1:0]; id_use_rs1 = u1;
        id_rs2 = rs2[ADDR_WIDTH-1:0]; id_use_rs2 = u2;
        id_rd = rd[ADDR_WIDTH-1:0];   id_rd_wen = wen;
        wb_valid = wbv; wb_rd = wbrd[ADDR_WIDTH-1:0]; wb_wen = wbwen; flush = fl;
        #2;
        exp_stall = v && !fl && ((u1 && rs1 != 0 && m_cnt[rs1] != 0) ||
                                 (u2 && rs2 != 0 && m_cnt[rs2] != 0) ||
                                 (wen && rd != 0 && m_cnt[rd] == CMAX));
        last_stall = id_stall;
        chk({tag, "_stall"}, {31'd0, id_stall}, {31'd0, exp_stall});
        iss = v && !exp_stall && !fl && wen && rd != 0;
        ret = wbv && wbwen && wbrd != 0 && !fl;
        if (fl) begin
            for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        end else begin
            if (ret && m_cnt[wbrd] == 0) m_err = 1'b1;
            if (!(iss && ret && rd == wbrd)) begin
                if (iss) m_cnt[rd]++;
                if (ret && m_cnt[wbrd] > 0) m_cnt[wbrd]--;
            end
        end
        e.busy = model_busy();
        e.err  = m_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            o = sb_q.pop_front();
            chk({tag, "_busy"}, {16'd0, busy_mask}, {16'd0, o.busy});
            chk({tag, "_err"}, {31'd0, sb_err}, {31'd0, o.err});
        end
    endtask

    // Shorthands for common cycle shapes.
    task automatic idle(input string tag);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask
    task automatic issue(input int rd, input string tag);
        cyc(1, 0, 0, 0, 0, rd, 1, 0, 0, 0, 0, tag);
    endtask
    task automatic retire(input int rd, input string tag);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, rd, 1, 0, tag);
    endtask

    initial begin
        n_chk = 0; n_err = 0; m_err = 1'b0; last_stall = 1'b0;
        for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        rst_n = 1'b0;
        id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = '0; id_rd_wen = 0; wb_valid = 0; wb_rd = '0; wb_wen = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {16'd0, busy_mask}, 32'd0);
        chk("rst_err", {31'd0, sb_err}, 32'd0);
        chk("rst_stall", {31'd0, id_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAW on x3.
        issue(3, "t2_c0");
        cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, "t2_c1");
        chk("t2_c1_stall", {31'd0, last_stall}, 32'd1);
        cyc(1, 3, 1, 0, 0, 0, 0, 1, 3, 1, 0, "t2_c2");
        chk("t2_c2_stall", {31'd0, last_stall}, 32'd1);
        cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, "t2_c3");
        chk("t2_c3_stall", {31'd0, last_stall}, 32'd0);

        // Two writes in flight to x7, read via rs2.
        issue(7, "t3_i0");
        issue(7, "t3_i1");
        chk("t3_busy7", {31'd0, busy_mask[7]}, 32'd1);
        cyc(1, 0, 0, 7, 1, 0, 0, 1, 7, 1, 0, "t3_r0");
        chk("t3_r0_stall", {31'd0, last_stall}, 32'd1);
        cyc(1, 0, 0, 7, 1, 0, 0, 1, 7, 1, 0, "t3_r1");
        chk("t3_r1_stall", {31'd0, last_stall}, 32'd1);
        cyc(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, "t3_r2");
        chk("t3_r2_stall", {31'd0, last_stall}, 32'd0);

        // Saturation of x4 stalls a fourth writer even with no source use.
        issue(4, "t4_i0");
        issue(4, "t4_i1");
        issue(4, "t4_i2");
        chk("t4_busy4", {31'd0, busy_mask[4]}, 32'd1);
        cyc(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, "t4_sat");
        chk("t4_sat_stall", {31'd0, last_stall}, 32'd1);
        // Both sources on the same busy register.
        cyc(1, 4, 1, 4, 1, 0, 0, 1, 4, 1, 0, "t4_dual");
        chk("t4_dual_stall", {31'd0, last_stall}, 32'd1);
        retire(4, "t4_r1");
        retire(4, "t4_r2");
        chk("t4_clear", {16'd0, busy_mask}, 32'd0);

        // Simultaneous issue and retire on x6.
        issue(6, "t5_i0");
        cyc(1, 0, 0, 0, 0, 6, 1, 1, 6, 1, 0, "t5_both");
        chk("t5_both_stall", {31'd0, last_stall}, 32'd0);
        chk("t5_busy6", {31'd0, busy_mask[6]}, 32'd1);
        // Different indices in the same cycle.
        cyc(1, 0, 0, 0, 0, 8, 1, 1, 6, 1, 0, "t5_diff");
        chk("t5_diff_mask", {16'd0, busy_mask}, 32'h0000_0100);
        retire(8, "t5_r8");

        // Errors, x0 and flush.
        retire(9, "t6_err");
        chk("t6_err_set", {31'd0, sb_err}, 32'd1);
        idle("t6_sticky");
        chk("t6_err_sticky", {31'd0, sb_err}, 32'd1);
        issue(0, "t6_x0");
        chk("t6_x0_mask", {16'd0, busy_mask}, 32'd0);
        cyc(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, "t6_x0_read");
        issue(2, "t6_i2");
        cyc(1, 2, 1, 0, 0, 5, 1, 1, 2, 1, 1, "t6_flush");
        chk("t6_flush_stall", {31'd0, last_stall}, 32'd0);
        chk("t6_flush_mask", {16'd0, busy_mask}, 32'd0);
        chk("t6_flush_err", {31'd0, sb_err}, 32'd1);

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, NREG - 1), $urandom_range(0, 1),
                $urandom_range(0, NREG - 1), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                ($urandom_range(0, 31) == 0), "rnd");
        end

        // Asynchronous reset in mid-cycle with x5 holding two writes.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t1_pre");
        issue(5, "t1_i0");
        issue(5, "t1_i1");
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, "t1_dep");
        chk("t1_dep_stall", {31'd0, last_stall}, 32'd1);
        id_valid = 1'b1; id_rs1 = 4'd5; id_use_rs1 = 1'b1;
        id_rd_wen = 1'b0; wb_valid = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_busy", {16'd0, busy_mask}, 32'd0);
        chk("t1_stall", {31'd0, id_stall}, 32'd0);
        chk("t1_err", {31'd0, sb_err}, 32'd0);
        for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, "t1_after");
        chk("t1_after_stall", {31'd0, last_stall}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
